// File: rtl/gray_code_counter.sv
// ---------------------------------------------------------------------------
// gray_code_counter
//   Parameterised up/down counter. It keeps a binary count internally and
//   registers the Gray encoding of that count, so gray_out is glitch-free and
//   every en-driven step (including a wrap) flips exactly one bit. It feeds
//   the gray2binary converter and serves as a pointer source for CDC logic.
//
// Parameters
//   WIDTH  counter / code width in bits (>= 2)
//   WRAP   1: wrap at the limits (max->0 up, 0->max down); 0: saturate
//
// Ports
//   clk       in   rising-edge clock
//   rst_n     in   asynchronous active-low reset
//   en        in   count-step request
//   up_dn     in   1 = increment, 0 = decrement (used only when en=1)
//   load      in   synchronous load of load_val, priority over en
//   load_val  in   [WIDTH] binary value to load
//   gray_out  out  [WIDTH] registered Gray code of the current count
//   gray_vld  out  1-cycle pulse: gray_out changed on this edge
//   wrap      out  1-cycle pulse: the last step crossed a limit
//   bin_out   out  [WIDTH] registered binary count; present only when the
//                  macro GRAY_CNT_BIN_OUT_EN is defined
//
// Handshake: gray_vld is a valid-only strobe with no ready. It is high for
// exactly the cycle after an edge that changed gray_out; a consumer must take
// gray_out in that cycle. Back-to-back steps keep gray_vld high continuously.
// ---------------------------------------------------------------------------
module gray_code_counter #(
  parameter int WIDTH = 4,
  parameter bit WRAP  = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] gray_out,
  output logic             gray_vld,
  output logic             wrap
`ifdef GRAY_CNT_BIN_OUT_EN
  ,
  output logic [WIDTH-1:0] bin_out
`endif
);

  localparam logic [WIDTH-1:0] MAX_VAL = '1;
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

  logic [WIDTH-1:0] bin_q;
  logic [WIDTH-1:0] nxt_bin;
  logic             nxt_vld;
  logic             nxt_wrap;

  // Next-count selection: load > en > hold.
  always_comb begin
    nxt_bin  = bin_q;
    nxt_vld  = 1'b0;
    nxt_wrap = 1'b0;
    if (load) begin
      nxt_bin = load_val;
      // Binary-to-Gray is a bijection, so the code changes iff the count does.
      nxt_vld = (load_val != bin_q);
    end else if (en) begin
      if (up_dn) begin
        if (bin_q != MAX_VAL) begin
          nxt_bin = bin_q + ONE;
          nxt_vld = 1'b1;
        end else if (WRAP) begin
          nxt_bin  = '0;
          nxt_vld  = 1'b1;
          nxt_wrap = 1'b1;
        end
      end else begin
        if (bin_q != '0) begin
          nxt_bin = bin_q - ONE;
          nxt_vld = 1'b1;
        end else if (WRAP) begin
          nxt_bin  = MAX_VAL;
          nxt_vld  = 1'b1;
          nxt_wrap = 1'b1;
        end
      end
    end
  end

  // Binary count and its Gray image are registered together on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_q    <= '0;
      gray_out <= '0;
      gray_vld <= 1'b0;
      wrap     <= 1'b0;
    end else begin
      bin_q    <= nxt_bin;
      gray_out <= nxt_bin ^ (nxt_bin >> 1);
      gray_vld <= nxt_vld;
      wrap     <= nxt_wrap;
    end
  end

`ifdef GRAY_CNT_BIN_OUT_EN
  assign bin_out = bin_q;
`endif

endmodule

// File: tb/tb_gray_code_counter.sv
// ---------------------------------------------------------------------------
// tb_gray_code_counter
//   Bench for gray_code_counter with WIDTH=4. Two instances share the same
//   stimulus: dut_w (WRAP=1) and dut_s (WRAP=0). A reference model predicts
//   {gray_out, gray_vld, wrap} per cycle and pushes it to a per-instance
//   expected queue; each test task pops and compares after the clock edge.
//   With GRAY_CNT_BIN_OUT_EN defined, bin_out is also checked against the
//   model count and against a Gray-to-binary conversion of gray_out.
// ---------------------------------------------------------------------------
module tb_gray_code_counter;

  localparam int WIDTH = 4;
  localparam int EW    = WIDTH + 2;

  logic             clk;
  logic             rst_n;
  logic             en;
  logic             up_dn;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] g_w, g_s;
  logic             v_w, v_s, w_w, w_s;
`ifdef GRAY_CNT_BIN_OUT_EN
  logic [WIDTH-1:0] b_w, b_s;
`endif

  int checks = 0;
  int errors = 0;

  logic [EW-1:0]    exp_w_q[$];
  logic [EW-1:0]    exp_s_q[$];
  logic [WIDTH-1:0] bin_w_q[$];
  logic [WIDTH-1:0] bin_s_q[$];
  logic [WIDTH-1:0] m_bin, m_sat;

  gray_code_counter #(.WIDTH(WIDTH), .WRAP(1'b1)) dut_w (
    .clk(clk), .rst_n(rst_n), .en(en), .up_dn(up_dn), .load(load),
    .load_val(load_val), .gray_out(g_w), .gray_vld(v_w), .wrap(w_w)
`ifdef GRAY_CNT_BIN_OUT_EN
    , .bin_out(b_w)
`endif
  );

  gray_code_counter #(.WIDTH(WIDTH), .WRAP(1'b0)) dut_s (
    .clk(clk), .rst_n(rst_n), .en(en), .up_dn(up_dn), .load(load),
    .load_val(load_val), .gray_out(g_s), .gray_vld(v_s), .wrap(w_s)
`ifdef GRAY_CNT_BIN_OUT_EN
    , .bin_out(b_s)
`endif
  );

  // ---------------- clock / watchdog ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1);
  end

  // ---------------- reference model ----------------
  task automatic model(input logic [WIDTH-1:0] cur, input bit wm,
                       input logic ld, input logic [WIDTH-1:0] lv,
                       input logic e, input logic ud,
                       output logic [WIDTH-1:0] nxt, output logic v,
                       output logic w);
    nxt = cur; v = 1'b0; w = 1'b0;
    if (ld) begin
      nxt = lv;
      v   = (lv != cur);
    end else if (e && ud) begin
      if (cur == 4'd15) begin
        if (wm) begin nxt = 4'd0; v = 1'b1; w = 1'b1; end
      end else begin
        nxt = cur + 4'd1; v = 1'b1;
      end
    end else if (e) begin
      if (cur == 4'd0) begin
        if (wm) begin nxt = 4'd15; v = 1'b1; w = 1'b1; end
      end else begin
        nxt = cur - 4'd1; v = 1'b1;
      end
    end
  endtask

  // ---------------- driver ----------------
  // Applies one cycle of stimulus, pushes predictions, returns at edge + 1.
  task automatic drive(input logic ld, input logic [WIDTH-1:0] lv,
                       input logic e, input logic ud);
    logic [WIDTH-1:0] n;
    logic v, w;
    load = ld; load_val = lv; en = e; up_dn = ud;
    model(m_bin, 1'b1, ld, lv, e, ud, n, v, w);
    exp_w_q.push_back({n ^ (n >> 1), v, w});
    bin_w_q.push_back(n);
    m_bin = n;
    model(m_sat, 1'b0, ld, lv, e, ud, n, v, w);
    exp_s_q.push_back({n ^ (n >> 1), v, w});
    bin_s_q.push_back(n);
    m_sat = n;
    @(posedge clk);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [EW-1:0] e6;
    rst_n = 1'b0; en = 1'b0; up_dn = 1'b1; load = 1'b0; load_val = '0;
    m_bin = '0; m_sat = '0;
    #3;
    checks++;
    if ({g_w, v_w, w_w, g_s, v_s, w_s} !== '0) begin
      errors++;
      $display("FAIL reset_init: got %b %b %b / %b %b %b, expected all 0",
               g_w, v_w, w_w, g_s, v_s, w_s);
    end
    @(posedge clk); #3; rst_n = 1'b1;
    // Count mid-stream, then reset asynchronously away from any edge.
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, '0, 1'b1, 1'b1);
      e6 = exp_w_q.pop_front(); void'(exp_s_q.pop_front());
      void'(bin_w_q.pop_front()); void'(bin_s_q.pop_front());
      checks++;
      if ({g_w, v_w, w_w} !== e6) begin
        errors++;
        $display("FAIL pre_reset_step%0d: got %b, expected %b", i, {g_w, v_w, w_w}, e6);
      end
    end
    #2; rst_n = 1'b0; #1;
    checks++;
    if ({g_w, v_w, w_w, g_s, v_s, w_s} !== '0) begin
      errors++;
      $display("FAIL async_reset: got %b %b %b / %b %b %b, expected all 0",
               g_w, v_w, w_w, g_s, v_s, w_s);
    end
    // Pending load/en while in reset must be ignored.
    load = 1'b1; load_val = 4'd9; en = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({g_w, v_w, w_w, g_s, v_s, w_s} !== '0) begin
      errors++;
      $display("FAIL reset_hold: got %b %b %b / %b %b %b, expected all 0",
               g_w, v_w, w_w, g_s, v_s, w_s);
    end
    load = 1'b0; en = 1'b0;
    #2; rst_n = 1'b1;
    m_bin = '0; m_sat = '0;
  endtask

  task automatic test_wrap_up();
    logic [WIDTH-1:0] tbl [16];
    logic [WIDTH-1:0] prev;
    logic [EW-1:0]    e6;
    tbl = '{4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100, 4'b1100,
            4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000, 4'b0000};
    prev = g_w;
    for (int i = 0; i < 16; i++) begin
      drive(1'b0, '0, 1'b1, 1'b1);
      e6 = exp_w_q.pop_front();
      checks++;
      if ({g_w, v_w, w_w} !== e6) begin
        errors++;
        $display("FAIL wrap_up_model%0d: got %b, expected %b", i, {g_w, v_w, w_w}, e6);
      end
      checks++;
      if (g_w !== tbl[i] || w_w !== (i == 15)) begin
        errors++;
        $display("FAIL wrap_up_table%0d: got %b wrap %b, expected %b wrap %b",
                 i, g_w, w_w, tbl[i], (i == 15));
      end
      checks++;
      if ($countones(g_w ^ prev) != 1) begin
        errors++;
        $display("FAIL one_bit%0d: got %b -> %b, expected 1 bit change", i, prev, g_w);
      end
      prev = g_w;
      e6 = exp_s_q.pop_front();
      void'(bin_w_q.pop_front()); void'(bin_s_q.pop_front());
      checks++;
      if ({g_s, v_s, w_s} !== e6) begin
        errors++;
        $display("FAIL sat_up%0d: got %b, expected %b", i, {g_s, v_s, w_s}, e6);
      end
    end
  endtask

  task automatic test_load_priority();
    drive(1'b1, 4'd10, 1'b1, 1'b1);
    void'(exp_w_q.pop_front()); void'(exp_s_q.pop_front());
    void'(bin_w_q.pop_front()); void'(bin_s_q.pop_front());
    checks++;
    if ({g_w, v_w, w_w} !== {4'b1111, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL load_beats_en: got %b, expected %b", {g_w, v_w, w_w}, {4'b1111, 2'b10});
    end
    drive(1'b1, 4'd10, 1'b0, 1'b0);
    void'(exp_w_q.pop_front()); void'(exp_s_q.pop_front());
    void'(bin_w_q.pop_front()); void'(bin_s_q.pop_front());
    checks++;
    if ({g_w, v_w, w_w, v_s} !== {4'b1111, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reload_same: got %b vld_s %b, expected 111100 vld_s 0",
               {g_w, v_w, w_w}, v_s);
    end
  endtask

  task automatic test_wrap_down();
    logic [EW-1:0] e6;
    drive(1'b1, 4'd0, 1'b0, 1'b0);
    void'(exp_w_q.pop_front()); void'(exp_s_q.pop_front());
    void'(bin_w_q.pop_front()); void'(bin_s_q.pop_front());
    drive(1'b0, '0, 1'b1, 1'b0);
    e6 = exp_w_q.pop_front();
    void'(bin_w_q.pop_front()); void'(bin_s_q.pop_front());
    checks++;
    if ({g_w, v_w, w_w} !== {4'b1000, 1'b1, 1'b1} || e6 !== {4'b1000, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL wrap_down: got %b, expected %b", {g_w, v_w, w_w}, {4'b1000, 2'b11});
    end
    e6 = exp_s_q.pop_front();
    checks++;
    if ({g_s, v_s, w_s} !== e6) begin
      errors++;
      $display("FAIL sat_floor: got %b, expected %b", {g_s, v_s, w_s}, e6);
    end
  endtask

  task automatic test_saturate();
    drive(1'b1, 4'd15, 1'b0, 1'b0);
    void'(exp_w_q.pop_front()); void'(exp_s_q.pop_front());
    void'(bin_w_q.pop_front()); void'(bin_s_q.pop_front());
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, '0, 1'b1, 1'b1);
      void'(exp_w_q.pop_front()); void'(exp_s_q.pop_front());
      void'(bin_w_q.pop_front()); void'(bin_s_q.pop_front());
      checks++;
      if ({g_s, v_s, w_s} !== {4'b1000, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL sat_hold%0d: got %b, expected %b", i, {g_s, v_s, w_s}, {4'b1000, 2'b00});
      end
    end
    drive(1'b0, '0, 1'b1, 1'b0);
    void'(exp_w_q.pop_front()); void'(exp_s_q.pop_front());
    void'(bin_w_q.pop_front()); void'(bin_s_q.pop_front());
    checks++;
    if ({g_s, v_s, w_s} !== {4'b1001, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL sat_down: got %b, expected %b", {g_s, v_s, w_s}, {4'b1001, 2'b10});
    end
  endtask

  task automatic test_random();
    logic [EW-1:0]    e6;
    logic [WIDTH-1:0] eb;
`ifdef GRAY_CNT_BIN_OUT_EN
    logic [WIDTH-1:0] conv;
`endif
    for (int i = 0; i < 40; i++) begin
      drive($urandom_range(0, 5) == 0, WIDTH'($urandom_range(0, 15)),
            $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1);
      e6 = exp_w_q.pop_front();
      checks++;
      if ({g_w, v_w, w_w} !== e6) begin
        errors++;
        $display("FAIL rand_w%0d: got %b, expected %b", i, {g_w, v_w, w_w}, e6);
      end
      e6 = exp_s_q.pop_front();
      checks++;
      if ({g_s, v_s, w_s} !== e6) begin
        errors++;
        $display("FAIL rand_s%0d: got %b, expected %b", i, {g_s, v_s, w_s}, e6);
      end
      eb = bin_w_q.pop_front();
      void'(bin_s_q.pop_front());
`ifdef GRAY_CNT_BIN_OUT_EN
      conv[WIDTH-1] = g_w[WIDTH-1];
      for (int k = WIDTH - 2; k >= 0; k--) conv[k] = conv[k+1] ^ g_w[k];
      checks++;
      if (b_w !== eb || conv !== b_w) begin
        errors++;
        $display("FAIL rand_bin%0d: got bin %b conv %b, expected %b", i, b_w, conv, eb);
      end
`else
      if (eb === 'x) $display("model count undefined at %0d", i);
`endif
    end
  endtask

  initial begin
    test_reset();
    test_wrap_up();
    test_load_priority();
    test_wrap_down();
    test_saturate();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
